spi_frame_ctrl: RTL and testbench

Frame sequencer for the SPI slave word serializer (the hoarder). Buffers up to FRAME_WORDS words from the processor side, then, once the SPI master opens a transfer, feeds them one by one into the serializer via its `wr` port. It tracks byte completions on the serializer's `ready` strobe, counts words, and reports frame completion and error conditions.

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_frame_buf.sv | 27 ++
 rtl/spi_frame_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame sequencer: state encoding, bytes-per-word helper, edge macros.
// Optional feature macro used by this slice: SPI_FRAME_CTRL_REPEAT_EN.
`ifndef SPI_PKG_SV
`define SPI_PKG_SV

`define SPI_EDGE_RISE(q, d) (~(q) & (d))
`define SPI_EDGE_FALL(q, d) ((q) & ~(d))

package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int calc_bpw(input int data_width, input int spi_width);
        return data_width / spi_width;
    endfunction

    // Index width that stays legal for a depth of one.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`endif

// File: rtl/spi_frame_buf.sv
// Frame word storage: one synchronous write port, one asynchronous read port.
module spi_frame_buf
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAME_WORDS = 4,
    parameter int PTR_W       = idx_w(FRAME_WORDS)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0]      rd_ptr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [FRAME_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/spi_frame_ctrl.sv
// Frame sequencer feeding buffered words into the SPI slave serializer one byte-group at a time.
// SPI_FRAME_CTRL_REPEAT_EN: when defined, a finished or aborted frame re-arms instead of clearing.
module spi_frame_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int FRAME_WORDS    = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load_wr,
    input  logic [DATA_WIDTH-1:0]              data_in,
    input  logic                               commit,
    input  logic                               start,
    input  logic                               byte_ready,
    output logic                               hw_wr,
    output logic [DATA_WIDTH-1:0]              hw_data,
    output logic                               busy,
    output logic                               frame_done,
    output logic [$clog2(FRAME_WORDS+1)-1:0]   word_cnt,
    output logic                               err
);

    localparam int BPW = calc_bpw(DATA_WIDTH, SPI_DATA_WIDTH);
    localparam int CW  = $clog2(FRAME_WORDS + 1);
    localparam int PW  = idx_w(FRAME_WORDS);
    localparam int BW  = idx_w(BPW);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FRAME_WORDS);
    localparam logic [BW-1:0] LAST_BYTE = BW'(BPW - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         word_cnt_q, word_cnt_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  ready_q, start_q;
    logic                  hw_wr_q, hw_wr_d;
    logic [DATA_WIDTH-1:0] hw_data_q, hw_data_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  err_q, err_d;

    logic                  byte_done, start_rise, start_fall;
    logic                  last_byte, last_word;
    logic                  buf_we;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;

    assign byte_done  = `SPI_EDGE_FALL(ready_q, byte_ready);
    assign start_rise = `SPI_EDGE_RISE(start_q, start);
    assign start_fall = `SPI_EDGE_FALL(start_q, start);
    assign last_byte  = (bcnt_q == LAST_BYTE);
    assign last_word  = (CW'(rptr_q) == (word_cnt_q - CW'(1)));

    // Read side looks ahead to the next word only while sending; otherwise it presents word 0.
    assign rd_ptr = (state_q == SEND && !start_fall) ? (rptr_q + PW'(1)) : '0;

    spi_frame_buf #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRAME_WORDS (FRAME_WORDS),
        .PTR_W       (PW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (word_cnt_q[PW-1:0]),
        .wr_data (data_in),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        rptr_d       = rptr_q;
        bcnt_d       = bcnt_q;
        hw_data_d    = hw_data_q;
        hw_wr_d      = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;
        buf_we       = 1'b0;

        if (byte_done && state_q != SEND) err_d = 1'b1;
        if (load_wr && state_q != IDLE)   err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (load_wr) begin
                    if (word_cnt_q == FULL_CNT) begin
                        err_d = 1'b1;
                    end else begin
                        buf_we     = 1'b1;
                        word_cnt_d = word_cnt_q + CW'(1);
                    end
                end
                // A word written in the commit cycle is not yet in the buffer, so bypass it.
                if (commit && word_cnt_d != '0) begin
                    state_d   = ARMED;
                    hw_data_d = (buf_we && word_cnt_q == '0) ? data_in : rd_data;
                end
            end
            ARMED: begin
                hw_data_d = rd_data;
                if (start_rise) begin
                    state_d = SEND;
                    rptr_d  = '0;
                    bcnt_d  = '0;
                    hw_wr_d = 1'b1;
                end
            end
            SEND: begin
                if (byte_done && last_byte && last_word) begin
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                end else if (start_fall) begin
                    err_d = 1'b1;
`ifdef SPI_FRAME_CTRL_REPEAT_EN
                    state_d   = ARMED;
                    hw_data_d = rd_data;
`else
                    state_d    = IDLE;
                    word_cnt_d = '0;
`endif
                end else if (byte_done) begin
                    if (last_byte) begin
                        rptr_d    = rptr_q + PW'(1);
                        bcnt_d    = '0;
                        hw_data_d = rd_data;
                        hw_wr_d   = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end
            default: begin
`ifdef SPI_FRAME_CTRL_REPEAT_EN
                state_d   = ARMED;
                hw_data_d = rd_data;
`else
                state_d    = IDLE;
                word_cnt_d = '0;
`endif
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            rptr_q       <= '0;
            bcnt_q       <= '0;
            ready_q      <= 1'b0;
            start_q      <= 1'b0;
            hw_wr_q      <= 1'b0;
            hw_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            rptr_q       <= rptr_d;
            bcnt_q       <= bcnt_d;
            ready_q      <= byte_ready;
            start_q      <= start;
            hw_wr_q      <= hw_wr_d;
            hw_data_q    <= hw_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign hw_wr      = hw_wr_q;
    assign hw_data    = hw_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign word_cnt   = word_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Scoreboard bench for spi_frame_ctrl: a frame-level model predicts load strobes and frame completions.
module tb_spi_frame_ctrl;

    localparam int DW  = 32;
    localparam int SW  = 8;
    localparam int FW  = 4;
    localparam int BPW = DW / SW;
    localparam int CW  = $clog2(FW + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_wr = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          commit = 1'b0;
    logic          start = 1'b0;
    logic          byte_ready = 1'b0;
    logic          hw_wr;
    logic [DW-1:0] hw_data;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] word_cnt;
    logic          err;

    always #5 clk = ~clk;

    spi_frame_ctrl #(
        .DATA_WIDTH     (DW),
        .SPI_DATA_WIDTH (SW),
        .FRAME_WORDS    (FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_wr    (load_wr),
        .data_in    (data_in),
        .commit     (commit),
        .start      (start),
        .byte_ready (byte_ready),
        .hw_wr      (hw_wr),
        .hw_data    (hw_data),
        .busy       (busy),
        .frame_done (frame_done),
        .word_cnt   (word_cnt),
        .err        (err)
    );

    typedef struct {
        int          tag;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    int  checks = 0;
    int  errors = 0;
    int  edge_cnt = 0;
    bit  cur_st = 1'b0;

    // Frame-level reference: the frame is a list of words, progress is a running byte count.
    logic [DW-1:0] m_words[$];
    bit m_armed, m_sending, m_done_cyc, m_err, m_prev_st, m_prev_rdy;
    int m_bytes;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    wr_t mon_e;
    int  mon_t;
    always @(negedge clk) begin
        if (!rst) begin
            if (hw_wr) begin
                if (exp_wr.size() == 0) begin
                    chk("hw_wr_unexpected", 64'(hw_wr), 64'd0);
                end else begin
                    mon_e = exp_wr.pop_front();
                    chk("hw_wr_cycle", 64'(edge_cnt), 64'(mon_e.tag));
                    chk("hw_data", 64'(hw_data), 64'(mon_e.data));
                end
            end
            if (frame_done) begin
                if (exp_done.size() == 0) begin
                    chk("frame_done_unexpected", 64'(frame_done), 64'd0);
                end else begin
                    mon_t = exp_done.pop_front();
                    chk("frame_done_cycle", 64'(edge_cnt), 64'(mon_t));
                end
            end
        end
    end

    task automatic model_clear();
        m_words.delete();
        exp_wr.delete();
        exp_done.delete();
        m_armed = 0; m_sending = 0; m_done_cyc = 0; m_err = 0;
        m_prev_st = 0; m_prev_rdy = 0; m_bytes = 0;
    endtask

    task automatic push_wr(input logic [DW-1:0] d);
        wr_t e;
        e.tag  = edge_cnt + 1;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic end_frame();
`ifdef SPI_FRAME_CTRL_REPEAT_EN
        m_armed = 1;
`else
        m_words.delete();
`endif
    endtask

    task automatic model(input bit ld, input logic [DW-1:0] d, input bit cm, input bit st, input bit rdy);
        bit bd, sr, sf;
        bd = m_prev_rdy && !rdy;
        sr = st && !m_prev_st;
        sf = m_prev_st && !st;
        m_prev_rdy = rdy;
        m_prev_st  = st;
        if (m_sending) begin
            if (ld) m_err = 1;
            if (bd) m_bytes++;
            if (bd && m_bytes == m_words.size() * BPW) begin
                exp_done.push_back(edge_cnt + 1);
                m_sending  = 0;
                m_done_cyc = 1;
            end else if (sf) begin
                m_err = 1;
                m_sending = 0;
                end_frame();
            end else if (bd && (m_bytes % BPW) == 0) begin
                push_wr(m_words[m_bytes / BPW]);
            end
        end else if (m_done_cyc) begin
            if (ld || bd) m_err = 1;
            m_done_cyc = 0;
            end_frame();
        end else if (m_armed) begin
            if (ld || bd) m_err = 1;
            if (sr) begin
                m_armed = 0;
                m_sending = 1;
                m_bytes = 0;
                push_wr(m_words[0]);
            end
        end else begin
            if (ld) begin
                if (m_words.size() == FW) m_err = 1;
                else m_words.push_back(d);
            end
            if (cm && m_words.size() > 0) m_armed = 1;
            if (bd) m_err = 1;
        end
    endtask

    task automatic step(input bit ld, input logic [DW-1:0] d, input bit cm, input bit st, input bit rdy);
        @(negedge clk);
        load_wr = ld; data_in = d; commit = cm; start = st; byte_ready = rdy;
        cur_st = st;
        model(ld, d, cm, st, rdy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, cur_st, 0);
    endtask

    task automatic byte_pulse();
        step(0, '0, 0, cur_st, 1);
        step(0, '0, 0, cur_st, 0);
    endtask

    task automatic check_status(input string tag);
        idle(1);
        @(posedge clk); #1;
        chk({tag, "_word_cnt"}, 64'(word_cnt), 64'(m_words.size()));
        chk({tag, "_err"}, 64'(err), 64'(m_err));
        chk({tag, "_busy"}, 64'(busy), 64'(m_armed || m_sending || m_done_cyc));
        if (m_armed) chk({tag, "_armed_data"}, 64'(hw_data), 64'(m_words[0]));
    endtask

    task automatic drain_check(input string tag);
        idle(3);
        #2;
        chk({tag, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
        chk({tag, "_done_left"}, 64'(exp_done.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        load_wr = 0; data_in = '0; commit = 0; start = 0; byte_ready = 0; cur_st = 0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic send_frame(input int nbytes);
        step(0, '0, 0, 1, 0);
        for (int b = 0; b < nbytes; b++) begin
            byte_pulse();
            idle($urandom_range(0, 2));
        end
        step(0, '0, 0, 0, 0);
    endtask

    initial begin
        int n, abort_at;
        logic [DW-1:0] w;
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_hw_wr", 64'(hw_wr), 64'd0);
        chk("rst_hw_data", 64'(hw_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 0;

        // Two-word frame
        step(1, 32'h11223344, 0, 0, 0);
        step(1, 32'h55667788, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        check_status("tp1_armed");
        send_frame(8);
        drain_check("tp1");
        check_status("tp1_end");

        // Overflow: fifth word dropped
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 32'hA0000000 + i, 0, 0, 0);
        check_status("ovf");
        chk("ovf_err_set", 64'(err), 64'd1);
        step(0, '0, 1, 0, 0);
        send_frame(FW * BPW);
        drain_check("ovf");

        // Empty commit, then load+commit together
        do_reset();
        step(0, '0, 1, 0, 0);
        check_status("empty_commit");
        step(1, 32'hCAFEF00D, 1, 0, 0);
        check_status("load_commit");
        send_frame(BPW);
        drain_check("load_commit");

        // Abort after two bytes of a one-word frame
        do_reset();
        step(1, 32'h0BADC0DE, 1, 0, 0);
        step(0, '0, 0, 1, 0);
        byte_pulse();
        byte_pulse();
        step(0, '0, 0, 0, 0);
        check_status("abort");
        chk("abort_err_set", 64'(err), 64'd1);
        byte_pulse();
        byte_pulse();
        drain_check("abort");
        check_status("abort_after");

`ifdef SPI_FRAME_CTRL_REPEAT_EN
        // Same frame resent without reloading
        do_reset();
        step(1, 32'hDEADBEEF, 1, 0, 0);
        send_frame(BPW);
        check_status("repeat_rearm");
        send_frame(BPW);
        drain_check("repeat");
`endif

        // Randomized frames, occasional aborts
        do_reset();
        for (int it = 0; it < 25; it++) begin
`ifdef SPI_FRAME_CTRL_REPEAT_EN
            do_reset();
`endif
            n = $urandom_range(1, FW);
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                step(1, w, (k == n - 1) && ($urandom_range(0, 1) == 1), 0, 0);
                idle($urandom_range(0, 1));
            end
            step(0, '0, 1, 0, 0);
            check_status("rnd_armed");
            abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, n * BPW - 1) : -1;
            step(0, '0, 0, 1, 0);
            for (int b = 0; b < n * BPW; b++) begin
                if (b == abort_at) break;
                byte_pulse();
                idle($urandom_range(0, 2));
            end
            step(0, '0, 0, 0, 0);
            drain_check("rnd");
            check_status("rnd_end");
        end

        // Asynchronous reset in the middle of a frame
        do_reset();
        step(1, 32'h13579BDF, 0, 0, 0);
        step(1, 32'h2468ACE0, 1, 0, 0);
        step(1, 32'hFFFFFFFF, 0, 0, 0);
        step(0, '0, 0, 1, 0);
        for (int b = 0; b < BPW + 1; b++) byte_pulse();
        #2;
        rst = 1;
        #1;
        chk("arst_hw_wr", 64'(hw_wr), 64'd0);
        chk("arst_hw_data", 64'(hw_data), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_frame_done", 64'(frame_done), 64'd0);
        chk("arst_word_cnt", 64'(word_cnt), 64'd0);
        chk("arst_err", 64'(err), 64'd0);
        load_wr = 0; data_in = '0; commit = 0; start = 0; byte_ready = 0; cur_st = 0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 0;
        check_status("arst_after");
        drain_check("arst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
